// File: rtl/credit_input_port.sv
// Credit-based router input port: per-VC flit FIFOs with XY route precompute,
// a per-VC IDLE/VA/ACTIVE packet FSM, registered crossbar output and credit return.
module credit_input_port #(
  parameter  int VC_NUM      = 2,
  parameter  int BUFFER_SIZE = 8,
  parameter  int PAYLOAD_W   = 16,
  parameter  int COORD_W     = 2,
  parameter  int X_CURRENT   = 1,
  parameter  int Y_CURRENT   = 1,
  localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flit_valid_i,
  input  logic [VC_W-1:0]          flit_vc_i,
  input  logic [1:0]               flit_type_i,
  input  logic [COORD_W-1:0]       flit_xdest_i,
  input  logic [COORD_W-1:0]       flit_ydest_i,
  input  logic [PAYLOAD_W-1:0]     flit_payload_i,
  input  logic [VC_NUM-1:0]        va_grant_i,
  input  logic [VC_NUM*VC_W-1:0]   va_vc_i,
  input  logic                     sa_valid_i,
  input  logic [VC_W-1:0]          sa_vc_i,
  output logic [VC_NUM-1:0]        vc_request_o,
  output logic [VC_NUM-1:0]        sa_request_o,
  output logic [VC_NUM*3-1:0]      out_port_o,
  output logic                     flit_valid_o,
  output logic [1:0]               flit_type_o,
  output logic [VC_W-1:0]          flit_vc_o,
  output logic [PAYLOAD_W-1:0]     flit_payload_o,
  output logic                     credit_valid_o,
  output logic [VC_W-1:0]          credit_vc_o,
  output logic                     error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] X_POS = COORD_W'(X_CURRENT);
  localparam logic [COORD_W-1:0] Y_POS = COORD_W'(Y_CURRENT);

  localparam logic [1:0] FLIT_HEAD     = 2'd0;
  localparam logic [1:0] FLIT_TAIL     = 2'd2;
  localparam logic [1:0] FLIT_HEADTAIL = 2'd3;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_WEST  = 3'd3;
  localparam logic [2:0] PORT_EAST  = 3'd4;

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_e;

  function automatic logic is_head(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  function automatic logic is_end(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

  // X is resolved before Y, which keeps XY routing deadlock-free in a mesh.
  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] xd,
                                          input logic [COORD_W-1:0] yd);
    if (xd > X_POS)      return PORT_EAST;
    else if (xd < X_POS) return PORT_WEST;
    else if (yd < Y_POS) return PORT_NORTH;
    else if (yd > Y_POS) return PORT_SOUTH;
    else                 return PORT_LOCAL;
  endfunction

  logic [VC_NUM-1:0]    pop_sa;
  logic [VC_NUM-1:0]    err_ev;
  logic [1:0]           front_type    [VC_NUM];
  logic [PAYLOAD_W-1:0] front_payload [VC_NUM];
  logic [VC_W-1:0]      down_vc       [VC_NUM];
  logic [2:0]           wr_route;

  assign wr_route = is_head(flit_type_i) ? xy_route(flit_xdest_i, flit_ydest_i) : PORT_LOCAL;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [1:0]           type_mem    [BUFFER_SIZE];
    logic [PAYLOAD_W-1:0] payload_mem [BUFFER_SIZE];
    logic [2:0]           route_mem   [BUFFER_SIZE];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    vc_state_e            state_q, state_d;
    logic [2:0]           port_q;
    logic [VC_W-1:0]      dvc_q;
    logic                 wr_req, wr_en, empty, full, pop_drop, pop;

    assign wr_req   = flit_valid_i && (flit_vc_i == VC_W'(v));
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(BUFFER_SIZE));
    assign pop_sa[v] = (state_q == ACTIVE) && !empty && sa_valid_i && (sa_vc_i == VC_W'(v));
    assign pop_drop = (state_q == IDLE) && !empty && !is_head(type_mem[rd_ptr]);
    assign pop      = pop_sa[v] || pop_drop;
    assign wr_en    = wr_req && (!full || pop);
    assign err_ev[v] = pop_drop || (wr_req && full && !pop);

    assign front_type[v]    = type_mem[rd_ptr];
    assign front_payload[v] = payload_mem[rd_ptr];
    assign down_vc[v]       = dvc_q;

    assign vc_request_o[v]       = (state_q == VA);
    assign sa_request_o[v]       = (state_q == ACTIVE) && !empty;
    assign out_port_o[v*3 +: 3]  = port_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (!empty && is_head(type_mem[rd_ptr])) state_d = VA;
        VA:      if (va_grant_i[v]) state_d = ACTIVE;
        ACTIVE:  if (pop_sa[v] && is_end(type_mem[rd_ptr])) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update off the same edge values.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        port_q  <= '0;
        dvc_q   <= '0;
      end else begin
        state_q <= state_d;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        unique case ({wr_en, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (state_q == IDLE && state_d == VA) port_q <= route_mem[rd_ptr];
        if (state_q == VA && va_grant_i[v])   dvc_q  <= va_vc_i[v*VC_W +: VC_W];
      end
    end

    // NOTE: storage is left unreset; an empty count already marks every entry invalid.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        type_mem[wr_ptr]    <= flit_type_i;
        payload_mem[wr_ptr] <= flit_payload_i;
        route_mem[wr_ptr]   <= wr_route;
      end
    end
  end

  logic                 pop_any;
  logic [1:0]           sel_type;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [VC_W-1:0]      sel_dvc;

  assign pop_any = |pop_sa;

  // At most one VC can match sa_vc_i, so the OR-style mux never collides.
  always_comb begin
    sel_type    = '0;
    sel_payload = '0;
    sel_dvc     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop_sa[v]) begin
        sel_type    = front_type[v];
        sel_payload = front_payload[v];
        sel_dvc     = down_vc[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_valid_o   <= 1'b0;
      flit_type_o    <= '0;
      flit_vc_o      <= '0;
      flit_payload_o <= '0;
      credit_valid_o <= 1'b0;
      credit_vc_o    <= '0;
      error_o        <= 1'b0;
    end else begin
      flit_valid_o   <= pop_any;
      credit_valid_o <= pop_any;
      if (pop_any) begin
        flit_type_o    <= sel_type;
        flit_vc_o      <= sel_dvc;
        flit_payload_o <= sel_payload;
        credit_vc_o    <= sa_vc_i;
      end
      error_o <= error_o || (|err_ev);
    end
  end

endmodule

// File: tb/tb_credit_input_port.sv
// Scoreboard bench for credit_input_port: expected flits are queued when SA grants
// are issued and compared against the registered crossbar/credit outputs.
module tb_credit_input_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flit_valid_i = 1'b0;
  logic [0:0]  flit_vc_i = '0;
  logic [1:0]  flit_type_i = '0;
  logic [1:0]  flit_xdest_i = '0;
  logic [1:0]  flit_ydest_i = '0;
  logic [15:0] flit_payload_i = '0;
  logic [1:0]  va_grant_i = '0;
  logic [1:0]  va_vc_i = '0;
  logic        sa_valid_i = 1'b0;
  logic [0:0]  sa_vc_i = '0;
  logic [1:0]  vc_request_o;
  logic [1:0]  sa_request_o;
  logic [5:0]  out_port_o;
  logic        flit_valid_o;
  logic [1:0]  flit_type_o;
  logic [0:0]  flit_vc_o;
  logic [15:0] flit_payload_o;
  logic        credit_valid_o;
  logic [0:0]  credit_vc_o;
  logic        error_o;

  credit_input_port dut (
    .clk            (clk),
    .rst            (rst),
    .flit_valid_i   (flit_valid_i),
    .flit_vc_i      (flit_vc_i),
    .flit_type_i    (flit_type_i),
    .flit_xdest_i   (flit_xdest_i),
    .flit_ydest_i   (flit_ydest_i),
    .flit_payload_i (flit_payload_i),
    .va_grant_i     (va_grant_i),
    .va_vc_i        (va_vc_i),
    .sa_valid_i     (sa_valid_i),
    .sa_vc_i        (sa_vc_i),
    .vc_request_o   (vc_request_o),
    .sa_request_o   (sa_request_o),
    .out_port_o     (out_port_o),
    .flit_valid_o   (flit_valid_o),
    .flit_type_o    (flit_type_o),
    .flit_vc_o      (flit_vc_o),
    .flit_payload_o (flit_payload_o),
    .credit_valid_o (credit_valid_o),
    .credit_vc_o    (credit_vc_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ftype;
    logic [0:0]  dvc;
    logic [15:0] payload;
    logic [0:0]  cvc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_flit(input logic vc, input logic [1:0] t, input logic [1:0] xd,
                            input logic [1:0] yd, input logic [15:0] p);
    flit_valid_i = 1'b1; flit_vc_i = vc; flit_type_i = t;
    flit_xdest_i = xd; flit_ydest_i = yd; flit_payload_i = p;
    tick();
    flit_valid_i = 1'b0;
  endtask

  task automatic va_grant(input logic [1:0] grant, input logic [1:0] vcs);
    va_grant_i = grant; va_vc_i = vcs;
    tick();
    va_grant_i = '0; va_vc_i = '0;
  endtask

  task automatic sa_pop(input logic vc, input logic [1:0] t, input logic dvc, input logic [15:0] p);
    exp_q.push_back('{ftype: t, dvc: dvc, payload: p, cvc: vc});
    sa_valid_i = 1'b1; sa_vc_i = vc;
    tick();
    sa_valid_i = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // HEADTAIL to (3,0) on VC0: request one cycle after the write, EAST route, one output flit.
  task automatic headtail_seq(input logic [15:0] p);
    write_flit(1'b0, 2'd3, 2'd3, 2'd0, p);
    check("ht_vcreq_early", vc_request_o, 2'b00);
    tick();
    check("ht_vcreq", vc_request_o, 2'b01);
    check("ht_route_east", out_port_o[2:0], 3'd4);
    va_grant(2'b01, 2'b01);
    check("ht_active_vcreq", vc_request_o, 2'b00);
    check("ht_sareq", sa_request_o, 2'b01);
    sa_pop(1'b0, 2'd3, 1'b1, p);
    check("ht_done_sareq", sa_request_o, 2'b00);
    check("ht_done_vcreq", vc_request_o, 2'b00);
  endtask

  // Output monitor: every emitted flit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (flit_valid_o || credit_valid_o) begin
      check("credit_pair", credit_valid_o, flit_valid_o);
      if (exp_q.size() == 0) begin
        check("unexpected_flit", flit_valid_o, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_type", flit_type_o, e.ftype);
        check("out_vc", flit_vc_o, e.dvc);
        check("out_payload", flit_payload_o, e.payload);
        check("credit_vc", credit_vc_o, e.cvc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vcreq", vc_request_o, 2'b00);
    check("rst_sareq", sa_request_o, 2'b00);
    check("rst_port", out_port_o, 6'd0);
    check("rst_fvalid", flit_valid_o, 1'b0);
    check("rst_cvalid", credit_valid_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Routing: HEADTAIL EAST on VC0
    headtail_seq(16'h00A1);

    // Packet on VC1 to the local node
    write_flit(1'b1, 2'd0, 2'd1, 2'd1, 16'h00B0);
    write_flit(1'b1, 2'd1, 2'd0, 2'd0, 16'h00B1);
    write_flit(1'b1, 2'd2, 2'd0, 2'd0, 16'h00B2);
    check("pkt_vcreq", vc_request_o, 2'b10);
    check("pkt_route_local", out_port_o[5:3], 3'd0);
    check("pkt_sareq_va", sa_request_o, 2'b00);
    va_grant(2'b10, 2'b10);
    check("pkt_sareq", sa_request_o, 2'b10);
    sa_pop(1'b1, 2'd0, 1'b1, 16'h00B0);
    sa_pop(1'b1, 2'd1, 1'b1, 16'h00B1);
    sa_pop(1'b1, 2'd2, 1'b1, 16'h00B2);
    check("pkt_idle_vcreq", vc_request_o, 2'b00);
    check("pkt_idle_sareq", sa_request_o, 2'b00);
    check("pkt_no_error", error_o, 1'b0);

    // Interleaved packets: VC0 WEST, VC1 SOUTH
    write_flit(1'b0, 2'd0, 2'd0, 2'd1, 16'h00C0);
    write_flit(1'b1, 2'd0, 2'd1, 2'd2, 16'h00D0);
    write_flit(1'b0, 2'd2, 2'd0, 2'd0, 16'h00C1);
    write_flit(1'b1, 2'd1, 2'd0, 2'd0, 16'h00D1);
    write_flit(1'b1, 2'd2, 2'd0, 2'd0, 16'h00D2);
    check("il_routes", out_port_o, {3'd2, 3'd3});
    check("il_vcreq", vc_request_o, 2'b11);
    va_grant(2'b11, 2'b01);
    check("il_sareq", sa_request_o, 2'b11);
    sa_pop(1'b0, 2'd0, 1'b1, 16'h00C0);
    sa_pop(1'b1, 2'd0, 1'b0, 16'h00D0);
    sa_pop(1'b0, 2'd2, 1'b1, 16'h00C1);
    sa_pop(1'b1, 2'd1, 1'b0, 16'h00D1);
    sa_pop(1'b1, 2'd2, 1'b0, 16'h00D2);
    sa_valid_i = 1'b1; sa_vc_i = 1'b0;
    tick();
    sa_valid_i = 1'b0;
    check("il_idle_sareq", sa_request_o, 2'b00);
    tick();

    // Protocol error: BODY at an IDLE VC
    write_flit(1'b1, 2'd1, 2'd0, 2'd0, 16'h0055);
    check("proto_err_early", error_o, 1'b0);
    tick();
    check("proto_err", error_o, 1'b1);
    check("proto_vcreq", vc_request_o, 2'b00);
    tick();
    check("proto_err_sticky", error_o, 1'b1);
    check("proto_vcreq2", vc_request_o, 2'b00);
    check("proto_sareq", sa_request_o, 2'b00);

    // Full FIFO on VC0
    do_reset();
    check("full_err_cleared", error_o, 1'b0);
    write_flit(1'b0, 2'd0, 2'd2, 2'd1, 16'hE000);
    for (int i = 1; i < 8; i++) write_flit(1'b0, 2'd1, 2'd0, 2'd0, 16'hE000 + 16'(i));
    check("full_no_err", error_o, 1'b0);
    check("full_route_east", out_port_o[2:0], 3'd4);
    write_flit(1'b0, 2'd1, 2'd0, 2'd0, 16'hE008);
    check("full_drop_err", error_o, 1'b1);
    va_grant(2'b01, 2'b01);
    flit_valid_i = 1'b1; flit_vc_i = 1'b0; flit_type_i = 2'd2; flit_payload_i = 16'hE009;
    exp_q.push_back('{ftype: 2'd0, dvc: 1'b1, payload: 16'hE000, cvc: 1'b0});
    sa_valid_i = 1'b1; sa_vc_i = 1'b0;
    tick();
    flit_valid_i = 1'b0; sa_valid_i = 1'b0;
    for (int i = 1; i < 8; i++) sa_pop(1'b0, 2'd1, 1'b1, 16'hE000 + 16'(i));
    check("full_last_pending", sa_request_o, 2'b01);
    sa_pop(1'b0, 2'd2, 1'b1, 16'hE009);
    check("full_drained", sa_request_o, 2'b00);
    check("full_idle", vc_request_o, 2'b00);

    // Reset mid-packet on VC1 (NORTH)
    do_reset();
    write_flit(1'b1, 2'd0, 2'd1, 2'd0, 16'h00F0);
    write_flit(1'b1, 2'd1, 2'd0, 2'd0, 16'h00F1);
    write_flit(1'b1, 2'd2, 2'd0, 2'd0, 16'h00F2);
    check("mid_route_north", out_port_o[5:3], 3'd1);
    va_grant(2'b10, 2'b10);
    sa_pop(1'b1, 2'd0, 1'b1, 16'h00F0);
    sa_pop(1'b1, 2'd1, 1'b1, 16'h00F1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_fvalid", flit_valid_o, 1'b0);
    check("mid_cvalid", credit_valid_o, 1'b0);
    check("mid_payload", flit_payload_o, 16'h0000);
    check("mid_port", out_port_o, 6'd0);
    check("mid_sareq", sa_request_o, 2'b00);
    check("mid_vcreq", vc_request_o, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    headtail_seq(16'h007E);
    sa_valid_i = 1'b1; sa_vc_i = 1'b1;
    tick();
    sa_valid_i = 1'b0;
    repeat (3) tick();

    // Drain: every expected flit must have been seen
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
